pixel_row_packer: RTL

//  Streaming serial-to-parallel packer for the MJPEG front end.
//  - Accepts one signed pixel per valid/ready beat and sign-extends it to SAMP_W.
//  - Packs ROW_LEN samples into one row word for the DCT input stage.
//  - Ping-pong (two-slot) buffering, so input keeps streaming while the DCT stalls.
//  - Tags every row with its index inside the block, plus a last-row-of-block flag.

---
 rtl/mjpeg_pkg.sv | 27 ++
 rtl/pixel_row_slot.sv | 51 +++++
 rtl/pixel_row_packer.sv | 111 +++++++++++
 3 files changed

// File: rtl/mjpeg_pkg.sv
// Shared MJPEG front-end definitions: DCT sample/row defaults, row-word type,
// ping-pong slot selector and the pixel sign-extension helper used by the DCT stage.
package mjpeg_pkg;

  localparam int unsigned DCT_PIX_W        = 8;
  localparam int unsigned DCT_SAMP_W       = 12;
  localparam int unsigned DCT_ROW_LEN      = 8;
  localparam int unsigned DCT_ROWS_PER_BLK = 8;

  typedef logic [DCT_SAMP_W-1:0]             sample_t;
  typedef logic [DCT_ROW_LEN*DCT_SAMP_W-1:0] row_word_t;

  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_sel_t;

  // Two's-complement pixel to DCT sample, sign bit replicated upward.
  function automatic sample_t sign_ext(input logic [DCT_PIX_W-1:0] pix);
    return sample_t'($signed(pix));
  endfunction

  function automatic slot_sel_t other_slot(input slot_sel_t s);
    return (s == SLOT_A) ? SLOT_B : SLOT_A;
  endfunction

endpackage

// File: rtl/pixel_row_slot.sv
// One ping-pong slot: ROW_LEN x SAMP_W register bank with per-column write,
// zero-padding of the unwritten tail when the row closes, and a full flag.
module pixel_row_slot #(
  parameter int unsigned SAMP_W  = 12,
  parameter int unsigned ROW_LEN = 8,
  localparam int unsigned COL_W  = $clog2(ROW_LEN)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      wr_en,
  input  logic [COL_W-1:0]          wr_col,
  input  logic [SAMP_W-1:0]         wr_data,
  input  logic                      close,
  input  logic                      drain,
  output logic                      full,
  output logic [ROW_LEN*SAMP_W-1:0] data
);

  logic [ROW_LEN-1:0][SAMP_W-1:0] cols;

  assign data = cols;

  // Column store; on close every column beyond the written one is cleared so
  // a short (flushed) row never carries stale samples from an earlier row.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cols <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < ROW_LEN; i++) begin
        if (COL_W'(i) == wr_col) begin
          cols[i] <= wr_data;
        end else if (close && (COL_W'(i) > wr_col)) begin
          cols[i] <= '0;
        end
      end
    end
  end

  // Full flag: set by the closing write, cleared by the output handshake.
  // Both can never hit the same slot in one cycle (write needs empty, drain needs full).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full <= 1'b0;
    end else if (wr_en && close) begin
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_row_packer.sv
// Streaming serial-to-parallel pixel packer for the MJPEG front end.
// Accepts one pixel per valid/ready beat, sign-extends it to SAMP_W and packs
// ROW_LEN samples into a row word through two ping-pong slots. Rows carry
// their index within the block and a last-row-of-block flag.
// Build option: define LEVEL_SHIFT_EN to treat pix_data as unsigned and
// level-shift it by -2^(DATA_W-1) before sign extension.
module pixel_row_packer
  import mjpeg_pkg::*;
#(
  parameter int unsigned DATA_W       = DCT_PIX_W,
  parameter int unsigned SAMP_W       = DCT_SAMP_W,
  parameter int unsigned ROW_LEN      = DCT_ROW_LEN,
  parameter int unsigned ROWS_PER_BLK = DCT_ROWS_PER_BLK,
  localparam int unsigned IDX_W       = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      pix_valid,
  input  logic [DATA_W-1:0]         pix_data,
  input  logic                      pix_flush,
  output logic                      pix_ready,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [ROW_LEN*SAMP_W-1:0] row_data,
  output logic [IDX_W-1:0]          row_idx,
  output logic                      blk_last
);

  localparam int unsigned COL_W = $clog2(ROW_LEN);

  logic [COL_W-1:0]                    col_cnt;
  slot_sel_t                           fill_ptr;
  slot_sel_t                           drain_ptr;
  logic [1:0]                          slot_full;
  logic [1:0][ROW_LEN*SAMP_W-1:0]      slot_data;
  logic [1:0]                          fill_hot;
  logic [1:0]                          drain_hot;
  logic                                accept;
  logic                                close_row;
  logic                                last_col;
  logic                                out_fire;
  logic [DATA_W-1:0]                   pix_adj;
  logic [SAMP_W-1:0]                   sample;

  // Input conditioning: optional level shift, then sign extension to SAMP_W.
  always_comb begin
    pix_adj = pix_data;
`ifdef LEVEL_SHIFT_EN
    pix_adj[DATA_W-1] = ~pix_data[DATA_W-1];
`endif
    sample = SAMP_W'($signed(pix_adj));
  end

  assign fill_hot  = (fill_ptr  == SLOT_B) ? 2'b10 : 2'b01;
  assign drain_hot = (drain_ptr == SLOT_B) ? 2'b10 : 2'b01;

  // Only state registers feed pix_ready, so row_ready has no path into it.
  assign pix_ready = ~|(slot_full & fill_hot);
  assign row_valid = |(slot_full & drain_hot);
  assign row_data  = (drain_ptr == SLOT_B) ? slot_data[1] : slot_data[0];
  assign blk_last  = (row_idx == IDX_W'(ROWS_PER_BLK - 1));

  assign last_col  = (col_cnt == COL_W'(ROW_LEN - 1));
  assign accept    = pix_valid & pix_ready;
  assign close_row = accept & (last_col | pix_flush);
  assign out_fire  = row_valid & row_ready;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    pixel_row_slot #(
      .SAMP_W (SAMP_W),
      .ROW_LEN(ROW_LEN)
    ) u_slot (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .wr_en    (accept & fill_hot[s]),
      .wr_col   (col_cnt),
      .wr_data  (sample),
      .close    (close_row & fill_hot[s]),
      .drain    (out_fire & drain_hot[s]),
      .full     (slot_full[s]),
      .data     (slot_data[s])
    );
  end

  // Fill side: column counter and fill pointer advance on accepted beats.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_cnt  <= '0;
      fill_ptr <= SLOT_A;
    end else if (accept) begin
      if (close_row) begin
        col_cnt  <= '0;
        fill_ptr <= other_slot(fill_ptr);
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Drain side: drain pointer and row index advance on each output handshake.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drain_ptr <= SLOT_A;
      row_idx   <= '0;
    end else if (out_fire) begin
      drain_ptr <= other_slot(drain_ptr);
      row_idx   <= blk_last ? '0 : row_idx + 1'b1;
    end
  end

endmodule
